// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: opcodes, fetch FSM encodings and the default reset PC.
package mips_defs_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC selection: jump beats taken branch beats sequential; purely combinational.
module next_pc_logic (
    input  logic [31:0] pc_plus4,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            // Offset is in words; the shift drops its top two bits, matching 32-bit wrap.
            next_pc = pc_plus4 + {branch_offset[29:0], 2'b00};
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC holder and fetch FSM: memory response in cycle N gives instr_valid in N+1; accept in M requests next PC in M+1.
// Backpressure: instruction held in HOLD (no new request) until instr_ready; memory may stall FETCH indefinitely.
module instr_fetch_unit
    import mips_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target
);

    fetch_state_t state;
    logic [31:0]  next_pc;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign op        = instr[31:26];

    next_pc_logic u_next_pc (
        .pc_plus4      (pc_plus4),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .next_pc       (next_pc)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= FETCH;
            pc          <= {RESET_PC[31:2], 2'b00};
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    // Only out of reset is req low here; a response counts only against a live request.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_valid) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc          <= next_pc;
                        instr       <= '0;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the MIPS main control decoder.
- Holds the PC and fetches 32-bit instructions from an instruction memory that may take a variable number of cycles to respond.
- Presents each instruction, and its op field, to the decode/execute stage with a valid/ready handshake.
- Computes the next PC from the sequential, beq-taken and j redirects returned by the datapath when an instruction is accepted.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request; held high until imem_valid.
- imem_addr  out  32  fetch address (= pc); stable while imem_req is high.
- imem_rdata  in  32  instruction word; valid when imem_valid is high.
- imem_valid  in  1  response strobe; may assert in the same cycle as imem_req, or any later cycle.
- instr  out  32  registered instruction word.
- op  out  6  instr[31:26], feeds the control decoder.
- instr_valid  out  1  instr/op/pc/pc_plus4 hold a fetched instruction.
- instr_ready  in  1  datapath accepts the current instruction this cycle.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- branch_taken  in  1  branch & zero for the accepted instruction.
- branch_offset  in  32  sign-extended imm16 for the accepted instruction.
- jump  in  1  accepted instruction is j.
- jump_target  in  26  instr[25:0] for the accepted instruction.

Behaviour:
- Reset (reset_n = 0 at a rising edge): pc = RESET_PC, instr = 0, instr_valid = 0, imem_req = 0, state = FETCH.
  - Reset overrides everything, including an outstanding fetch or a pending accept.
  - The instruction memory shares reset_n, so no stale response survives reset.
- FSM states: FETCH and HOLD.
- FETCH:
  - imem_req = 1 and imem_addr = pc.
  - On a cycle with imem_valid = 1: instr <= imem_rdata, instr_valid <= 1, go to HOLD.
  - Otherwise remain in FETCH with imem_req held and the address stable.
- HOLD:
  - imem_req = 0 and instr_valid = 1.
  - instr, pc and pc_plus4 are held stable until accepted.
  - imem_valid is ignored in this state.
- Accept (HOLD and instr_ready = 1):
  - pc <= next_pc, instr_valid <= 0, go to FETCH.
  - The new request is issued in the following cycle.
- Latency:
  - imem_valid in cycle N gives instr_valid = 1 in cycle N+1.
  - An accept in cycle M gives imem_req = 1 with the new address in cycle M+1.
  - Best-case throughput is 1 instruction per 2 cycles.
- next_pc priority:
  - jump = 1: next_pc = {pc_plus4[31:28], jump_target, 2'b00}.
  - else branch_taken = 1: next_pc = pc_plus4 + (branch_offset << 2), 32-bit wrap.
  - else: next_pc = pc_plus4.
  - jump and branch_taken both 1: jump wins.
  - branch_taken, branch_offset, jump and jump_target are sampled only in the accept cycle; they are don't-care otherwise.
- Wrap-around: pc = 32'hFFFF_FFFC gives pc_plus4 = 0, and sequential next_pc = 0.
- Alignment: pc[1:0] is always 0.
- op = instr[31:26], combinational from the register; it is 0 (R-type) while instr_valid = 0. Consumers must qualify op with instr_valid.
- instr_ready while instr_valid = 0 has no effect.

Decomposition:
- Shared header mips_defs:
  - opcode constants OP_RTYPE 6'b000000, OP_ADDI 6'b001000, OP_BEQ 6'b000100, OP_J 6'b000010, OP_LW 6'b100011, OP_SW 6'b101011.
  - fetch FSM state encodings FETCH and HOLD.
  - default RESET_PC.
- One combinational sub-module, next_pc_logic (pc_plus4, jump, jump_target, branch_taken, branch_offset -> next_pc).
  - Reused later by a pipelined variant.

Test Plan:
1. Reset held 3 cycles, then released; memory responds in the same cycle as the request with 32'h2008_0005 (addi) -> imem_req = 1 at addr 0 in the first cycle after release; next cycle instr_valid = 1, op = 6'b001000, pc = 0.
2. Memory responds 4 cycles after each request; 3 sequential instructions, each accepted as soon as valid -> addresses 0, 4, 8 in order; imem_addr stable throughout each wait; instr_valid never high while imem_req is high.
3. beq at pc = 32'h0000_0010 accepted with branch_taken = 1 and branch_offset = 32'hFFFF_FFFD -> next imem_addr = 32'h0000_0008.
4. j at pc = 32'h1000_0040 accepted with jump_target = 26'h000_0100 and branch_taken = 1 both asserted -> next imem_addr = 32'h1000_0400 (jump wins).
5. instr_ready held low 5 cycles in HOLD while spurious imem_valid pulses arrive -> instr, pc and instr_valid unchanged and no new request; pc = 32'hFFFF_FFFC accepted sequentially -> next imem_addr = 0.
6. reset_n pulsed low for 1 cycle while a FETCH at 32'h0000_0020 is outstanding -> next cycle pc = RESET_PC, instr_valid = 0; the new request goes to RESET_PC.
